// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-channel FSM state
// encoding, default acceptance window and counter sizing helper.
package debounce_pkg;

  // 50 MHz clock, 10 ms of stable input before a new level is accepted.
  localparam int DEFAULT_STABLE_CYCLES = 500000;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } db_state_t;

  // Counter must hold values up to and including the acceptance window.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: two-flop synchronizer feeding a four-state
// acceptance FSM with a run-length counter. The clean output is a flop.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam int                CNT_W  = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  LIMIT  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
  // A one-sample window accepts immediately; the pending states are skipped.
  localparam bit                SINGLE = (STABLE_CYCLES == 1);

  logic             sync1;
  logic             sync2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             clean_nxt;

  assign cnt_inc = cnt + ONE;

  // Synchronizer, FSM state, run counter and registered clean level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= STABLE_LOW;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
  end

  // Next state: count consecutive opposite samples, fall back on any bounce.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      STABLE_LOW: begin
        if (sync2) begin
          if (SINGLE) begin
            state_nxt = STABLE_HIGH;
          end else begin
            state_nxt = PEND_HIGH;
            cnt_nxt   = ONE;
          end
        end
      end
      PEND_HIGH: begin
        if (!sync2) begin
          state_nxt = STABLE_LOW;
        end else if (cnt_inc == LIMIT) begin
          state_nxt = STABLE_HIGH;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!sync2) begin
          if (SINGLE) begin
            state_nxt = STABLE_LOW;
          end else begin
            state_nxt = PEND_LOW;
            cnt_nxt   = ONE;
          end
        end
      end
      PEND_LOW: begin
        if (sync2) begin
          state_nxt = STABLE_HIGH;
        end else if (cnt_inc == LIMIT) begin
          state_nxt = STABLE_LOW;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
      end
    endcase
  end

  // Output level follows the accepted level, which pending states do not change.
  always_comb begin
    clean_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == PEND_LOW);
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: WIDTH independent channels, each with
// its own synchronizer, acceptance FSM and counter.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawButtons,
  output logic [WIDTH-1:0] cleanButtons
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (rawButtons[i]),
      .clean(cleanButtons[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (window 4 and window 1) share the
// same stimulus; a window-based reference model feeds a scoreboard queue that
// a negedge monitor drains, plus directed edge-accurate checks.
module tb_button_debouncer;

  logic       clk;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] clean4;
  logic [3:0] clean1;

  int tests = 0;
  int fails = 0;

  button_debouncer #(.WIDTH(4), .STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .rawButtons(raw), .cleanButtons(clean4)
  );

  button_debouncer #(.WIDTH(4), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .rawButtons(raw), .cleanButtons(clean1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples per edge; a reset edge flushes its own
  // sample and the one before it (both synchronizer flops clear). The clean
  // level toggles at edge t when every raw sample from edges t-1-N..t-2
  // differs from the current clean level.
  logic [3:0] hist[$];
  logic [3:0] m4 = '0;
  logic [3:0] m1 = '0;
  logic [3:0] q4[$];
  logic [3:0] q1[$];

  function automatic logic run_differs(input logic [3:0] h[$], input int n,
                                       input int ch, input logic cur);
    int sz;
    logic s;
    sz = h.size();
    for (int j = sz - 1 - n; j <= sz - 2; j++) begin
      s = (j >= 0) ? h[j][ch] : 1'b0;
      if (s == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      if (hist.size() > 0) hist[hist.size()-1] = '0;
      hist.push_back('0);
      m4 = '0;
      m1 = '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        if (run_differs(hist, 4, ch, m4[ch])) m4[ch] = ~m4[ch];
        if (run_differs(hist, 1, ch, m1[ch])) m1[ch] = ~m1[ch];
      end
      hist.push_back(raw);
    end
    if (hist.size() > 8) void'(hist.pop_front());
    q4.push_back(m4);
    q1.push_back(m1);
  end

  // Monitor: one comparison per DUT per clock, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e;
    if (q4.size() == 0 || q1.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: q4=%0d q1=%0d entries, required >0", q4.size(), q1.size());
    end else begin
      e = q4.pop_front();
      tests++;
      if (clean4 !== e) begin
        fails++;
        $display("FAIL sb_w4 t=%0t: got %b expected %b", $time, clean4, e);
      end
      e = q1.pop_front();
      tests++;
      if (clean1 !== e) begin
        fails++;
        $display("FAIL sb_w1 t=%0t: got %b expected %b", $time, clean1, e);
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic rs);
    @(negedge clk);
    raw   = r;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int e, input logic [3:0] got,
                     input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s edge %0d: got %b expected %b", name, e, got, exp);
    end
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    int den;
    raw   = '0;
    reset = 1'b1;

    // Reset state
    do_reset();
    chk("reset_w4", 0, clean4, 4'b0000);
    chk("reset_w1", 0, clean1, 4'b0000);

    // Single press on channel 0, window 4
    for (int e = 0; e < 8; e++) begin
      step(4'b0001, 1'b0);
      chk("press_ch0", e, clean4, (e >= 5) ? 4'b0001 : 4'b0000);
    end

    // Bouncing channel 1: toggles every 2 edges, then held high from edge 8
    do_reset();
    for (int e = 0; e < 15; e++) begin
      r = (e >= 8) ? 4'b0010 : (((e / 2) % 2 == 0) ? 4'b0010 : 4'b0000);
      step(r, 1'b0);
      chk("bounce_ch1", e, clean4, (e >= 13) ? 4'b0010 : 4'b0000);
    end

    // Channel 2 established high, short 3-sample dropout must be ignored
    do_reset();
    for (int e = 0; e < 23; e++) begin
      r = (e >= 10 && e < 13) ? 4'b0000 : 4'b0100;
      step(r, 1'b0);
      if (e >= 5) chk("dropout_ch2", e, clean4, 4'b0100);
    end

    // All held high, reset pulsed at edge 3 while pending
    do_reset();
    for (int e = 0; e < 12; e++) begin
      step(4'b1111, (e == 3) ? 1'b1 : 1'b0);
      chk("reset_midpend", e, clean4, (e >= 9) ? 4'b1111 : 4'b0000);
    end

    // Window 1: rise on edge 2, fall on edge 12
    do_reset();
    for (int e = 0; e < 15; e++) begin
      step((e < 10) ? 4'b1000 : 4'b0000, 1'b0);
      chk("w1_ch3", e, clean1, (e >= 2 && e < 12) ? 4'b1000 : 4'b0000);
    end

    // Randomized bouncing with varied flip rates and rare resets
    do_reset();
    r = '0;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 2))
        0:       den = 2;
        1:       den = 8;
        default: den = 32;
      endcase
      for (int e = 0; e < 50; e++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, den - 1) == 0) r[b] = ~r[b];
        step(r, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
